// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and constants for the FIFO frame reader.
//   state_e    : control FSM states
//   BUF_DEPTH  : skid buffer entries; also the total read credit
//   BUF_AW     : skid buffer pointer width
//   out_cnt_w  : width of the in-frame word index for a given frame length
package fifo_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 4;
  localparam int BUF_AW    = 2;

  // Index 0..frame_len-1 fits in clog2(frame_len) bits; frame_len >= 2.
  function automatic int out_cnt_w(input int frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/fifo_reader_skid_buf.sv
// Four-entry register FIFO that absorbs words already in flight from the
// FIFO RAM when the stream sink stalls.
//   clk, rst   : clock, synchronous active-high reset
//   push/push_data : write one word
//   pop        : retire the head word (only while count != 0)
//   count      : occupancy 0..BUF_DEPTH
//   head_data  : current head entry, straight from the storage registers
module fifo_reader_skid_buf
  import fifo_frame_reader_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DW-1:0]     push_data,
  input  logic              pop,
  output logic [BUF_AW:0]   count,
  output logic [DW-1:0]     head_data
);

  logic [BUF_DEPTH-1:0][DW-1:0] mem;
  logic [BUF_AW-1:0]            wr_ptr;
  logic [BUF_AW-1:0]            rd_ptr;

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  // The read-credit rule upstream keeps these from ever firing.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == (BUF_AW+1)'(BUF_DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && (count == '0)));

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains a FIFO read port into a valid/ready stream framed every FRAME_LEN
// words. Reads are issued only while the words already in flight plus the
// words sitting in the skid buffer leave room, so back-pressure never drops
// a word regardless of the RAM read latency.
//   rd_clk, rd_rst : clock, synchronous active-high reset
//   enable         : permits a new frame to start (sampled in IDLE / DRAIN exit)
//   fifo_rd_en/empty/data : FIFO read port, data RD_LATENCY cycles after rd_en
//   m_data/valid/ready/last : output stream, m_last on the final frame word
//   frame_done     : one-cycle pulse after the last-word handshake
//   frame_count    : completed frames, wrapping
//   busy           : FSM not idle
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_count,
  output logic                  busy
);

  localparam int OCW = out_cnt_w(FRAME_LEN);
  // issue_cnt must be able to hold FRAME_LEN itself.
  localparam int ICW = OCW + 1;
  localparam logic [OCW-1:0] LAST_IDX   = OCW'(FRAME_LEN - 1);
  localparam logic [ICW-1:0] ISSUE_LAST = ICW'(FRAME_LEN - 1);
  localparam logic [BUF_AW:0] CREDITS   = (BUF_AW+1)'(BUF_DEPTH);

  state_e                state;
  state_e                state_nxt;
  logic [ICW-1:0]        issue_cnt;
  logic [OCW-1:0]        out_cnt;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [BUF_AW:0]       buf_cnt;
  logic [BUF_AW:0]       inflight_cnt;
  logic                  push;
  logic                  pop;
  logic                  last_hs;
  logic                  credit_ok;

  // ---------------------------------------------------------------------------
  // Read credit
  // ---------------------------------------------------------------------------
  // Every set bit of vld_pipe is a read whose data has not reached the skid
  // buffer yet (the top bit is arriving this cycle). A pop in the same cycle
  // is deliberately not credited, keeping the check free of m_ready timing.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight_cnt = inflight_cnt + (BUF_AW+1)'(vld_pipe[i]);
  end

  assign credit_ok  = (buf_cnt + inflight_cnt) < CREDITS;
  assign fifo_rd_en = (state == RUN) && !fifo_rd_empty && credit_ok;

  // Shift in the read enable; truncation drops the oldest bit.
  always_ff @(posedge rd_clk) begin
    if (rd_rst)
      vld_pipe <= '0;
    else
      vld_pipe <= RD_LATENCY'({vld_pipe, fifo_rd_en});
  end

  assign push = vld_pipe[RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Skid buffer and stream side
  // ---------------------------------------------------------------------------
  fifo_reader_skid_buf #(
    .DW (DATA_WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .count     (buf_cnt),
    .head_data (m_data)
  );

  assign m_valid = (buf_cnt != '0);
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (out_cnt == LAST_IDX);
  assign last_hs = pop && (out_cnt == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // The last word is issued before DRAIN and handed over no earlier than
  // RD_LATENCY+1 cycles later, so last_hs is only ever seen in DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (fifo_rd_en && (issue_cnt == ISSUE_LAST)) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;

      if ((state == IDLE) || last_hs)
        issue_cnt <= '0;
      else if (fifo_rd_en)
        issue_cnt <= issue_cnt + 1'b1;

      if ((state == IDLE) || last_hs)
        out_cnt <= '0;
      else if (pop)
        out_cnt <= out_cnt + 1'b1;

      frame_done <= last_hs;
      if (last_hs)
        frame_count <= frame_count + CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Two readers (RD_LATENCY 1 and 2) run side by side from the same word source
// and the same enable/ready stimulus. Each has its own FIFO read-port model
// and a stream-level reference: words must come out in source order, framed
// every 8, with frame_done/frame_count following each last handshake.
module tb_fifo_frame_reader;

  localparam int DW = 32;
  localparam int FL = 8;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic enable = 1'b0;
  logic m_ready = 1'b1;

  logic [1:0]         rd_en, empty, m_valid, m_last, frame_done, busy;
  logic [1:0][DW-1:0] rd_data, m_data;
  logic [1:0][1:0]    fc;

  logic [DW-1:0] src [0:1023];
  int            src_wr = 0;
  int            cyc = 0;
  bit            tput_mode = 1'b0;
  int            rdy_mode = 0;
  int            ph = 0;
  logic [3:0]    bp_pat = 4'b1001;   // m_ready 1,0,0,1 repeating

  int n_chk = 0;
  int n_err = 0;

  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_frame_reader #(
      .DATA_WIDTH (DW),
      .RD_LATENCY (g + 1),
      .FRAME_LEN  (FL),
      .CNT_W      (2)
    ) u_dut (
      .rd_clk        (rd_clk),
      .rd_rst        (rd_rst),
      .enable        (enable),
      .fifo_rd_en    (rd_en[g]),
      .fifo_rd_empty (empty[g]),
      .fifo_rd_data  (rd_data[g]),
      .m_data        (m_data[g]),
      .m_valid       (m_valid[g]),
      .m_ready       (m_ready),
      .m_last        (m_last[g]),
      .frame_done    (frame_done[g]),
      .frame_count   (fc[g]),
      .busy          (busy[g])
    );

    // FIFO read port: latency 1 = data register only, latency 2 adds an output reg.
    int          rd_ptr = 0;
    logic [DW-1:0] st1 = '0;
    logic [DW-1:0] st2 = '0;
    assign empty[g]   = (rd_ptr == src_wr);
    assign rd_data[g] = (g == 0) ? st1 : st2;
    always @(posedge rd_clk) begin
      if (rd_rst) begin
        rd_ptr <= src_wr;
        st1    <= '0;
        st2    <= '0;
      end else begin
        if (rd_en[g]) begin
          st1    <= src[rd_ptr];
          rd_ptr <= rd_ptr + 1;
        end
        st2 <= st1;
      end
    end

    // Stream-level reference.
    int          exp_idx = 0;
    int          hs_in_frame = 0;
    int          reads = 0;
    int          hs = 0;
    int          frames_total = 0;
    int          t0 = 0;
    int          t_rd = 0;
    bit          done_due = 0;
    bit          prev_stall = 0;
    bit          seen_rd = 0;
    bit          seen_v = 0;
    logic [1:0]  exp_fc = '0;
    logic [DW-1:0] prev_data = '0;

    initial begin
      forever begin
        @(negedge rd_clk);
        if (rd_rst) begin
          exp_idx = src_wr; hs_in_frame = 0; reads = 0; hs = 0; frames_total = 0;
          done_due = 0; prev_stall = 0; seen_rd = 0; seen_v = 0; exp_fc = '0;
        end else begin
          check($sformatf("frame_done%0d", g), frame_done[g], done_due);
          check($sformatf("frame_count%0d", g), fc[g], exp_fc);
          check($sformatf("m_last%0d", g), m_last[g], m_valid[g] && (hs_in_frame == FL-1));
          if (prev_stall) begin
            check($sformatf("stall_valid%0d", g), m_valid[g], 1'b1);
            check($sformatf("stall_data%0d", g), m_data[g], prev_data);
          end
          if (rd_en[g]) begin
            check($sformatf("rd_when_empty%0d", g), empty[g], 1'b0);
            if (!seen_rd) begin seen_rd = 1; t_rd = cyc; end
            reads++;
          end
          if (m_valid[g] && !seen_v) begin
            seen_v = 1;
            check($sformatf("latency%0d", g), cyc - t_rd, g + 2);
          end
          done_due = 0;
          if (m_valid[g] && m_ready) begin
            check($sformatf("data%0d", g), m_data[g], src[exp_idx]);
            if (hs_in_frame == 0) t0 = cyc;
            if (hs_in_frame == FL-1) begin
              if (tput_mode) check($sformatf("throughput%0d", g), cyc - t0, FL-1);
              done_due = 1; exp_fc++; frames_total++; hs_in_frame = 0;
            end else begin
              hs_in_frame++;
            end
            exp_idx++; hs++;
          end
          prev_stall = m_valid[g] && !m_ready;
          prev_data  = m_data[g];
          check($sformatf("credit%0d", g), (reads - hs) <= 4, 1'b1);
          check($sformatf("overissue%0d", g), reads <= (frames_total + 1) * FL, 1'b1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
      case (rdy_mode)
        1:       begin m_ready = bp_pat[ph]; ph = (ph + 1) % 4; end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    src[src_wr] = w;
    src_wr++;
  endtask

  function automatic bit cond(input int kind, input int tgt);
    case (kind)
      0:       return busy == 2'b00;
      1:       return g_dut[0].hs_in_frame >= tgt && g_dut[1].hs_in_frame >= tgt;
      default: return g_dut[0].frames_total >= tgt && g_dut[1].frames_total >= tgt;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int kind, input int tgt, input int budget);
    int n = 0;
    while (!cond(kind, tgt) && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, cond(kind, tgt), 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s%0d", tag, i),
            {rd_en[i], m_valid[i], m_last[i], frame_done[i], fc[i], busy[i], m_data[i]}, '0);
  endtask

  initial begin
    int r0, r1;
    tick(3);
    check_reset_vals("reset_vals");
    rd_rst = 1'b0;

    // Continuous frames, always ready.
    for (int i = 0; i < 16; i++) push_word(DW'(i));
    tput_mode = 1'b1;
    enable = 1'b1;
    wait_for("two_frames", 2, 2, 300);
    tput_mode = 1'b0;
    check("fc_after_2_l1", fc[0], 2'd2);
    check("fc_after_2_l2", fc[1], 2'd2);

    // Underrun mid-frame: only three words available.
    for (int i = 16; i < 19; i++) push_word(DW'(i));
    wait_for("underrun_3_words", 1, 3, 60);
    tick(5);
    check("underrun_valid", m_valid, 2'b00);
    check("underrun_busy", busy, 2'b11);
    check("underrun_pos_l1", g_dut[0].hs_in_frame, 3);
    check("underrun_pos_l2", g_dut[1].hs_in_frame, 3);

    // Drop enable mid-frame; the frame still completes, then the block idles
    // even though the FIFO holds another frame's worth.
    enable = 1'b0;
    for (int i = 19; i < 32; i++) push_word(DW'(i));
    wait_for("idle_after_drop", 0, 0, 200);
    check("fc_after_drop_l1", fc[0], 2'd3);
    check("fc_after_drop_l2", fc[1], 2'd3);
    r0 = g_dut[0].reads;
    r1 = g_dut[1].reads;
    tick(20);
    check("idle_no_reads_l1", g_dut[0].reads, r0);
    check("idle_no_reads_l2", g_dut[1].reads, r1);
    check("idle_busy", busy, 2'b00);
    check("idle_valid", m_valid, 2'b00);

    // Back-pressure with ready pattern 1,0,0,1.
    rdy_mode = 1;
    enable = 1'b1;
    wait_for("bp_frame", 2, 4, 300);
    check("fc_wrap_l1", fc[0], 2'd0);
    check("fc_wrap_l2", fc[1], 2'd0);

    // Reset partway into the next frame; FIFO flushed alongside.
    for (int i = 32; i < 40; i++) push_word(DW'(i));
    wait_for("pre_reset_4_words", 1, 4, 200);
    rd_rst = 1'b1;
    tick(2);
    check_reset_vals("midreset_vals");
    rd_rst = 1'b0;
    rdy_mode = 0;
    for (int i = 100; i < 108; i++) push_word(DW'(i));
    wait_for("post_reset_frame", 2, 1, 200);
    check("fc_post_reset_l1", fc[0], 2'd1);
    check("fc_post_reset_l2", fc[1], 2'd1);

    // Random data and random ready for four more frames: count walks 2,3,0,1.
    rdy_mode = 2;
    for (int i = 0; i < 4 * FL; i++) push_word($urandom);
    wait_for("random_frames", 2, 5, 1000);
    rdy_mode = 0;
    tick(2);
    check("fc_final_l1", fc[0], 2'd1);
    check("fc_final_l2", fc[1], 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
